// File: rtl/cash_deposit_ctrl.sv
// cash_deposit_ctrl: ATM deposit sequencer; ports: start/amount_due/cancel control, note_valid/note_sel in with note_accept/note_reject pulses, balance, payout_valid/payout_ready/payout_amt handshake, paid/done/busy status
module cash_deposit_ctrl #(
  parameter int BAL_W = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BAL_W-1:0] amount_due,
  input  logic             cancel,
  input  logic             note_valid,
  input  logic [5:0]       note_sel,
  output logic             note_accept,
  output logic             note_reject,
  output logic [BAL_W-1:0] balance,
  output logic             payout_valid,
  input  logic             payout_ready,
  output logic [BAL_W-1:0] payout_amt,
  output logic             paid,
  output logic             done,
  output logic             busy
);
  localparam int TMO_W = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, COLLECT, PAYOUT, DONE} state_t;
  state_t state;
  logic [BAL_W-1:0] due;
  logic [TMO_W-1:0] tmo;
  logic [6:0] val;
  logic [BAL_W:0] sum;
  logic legal, fits, refund;
  always_comb begin
    val = note_sel[5] ? 7'd100 : note_sel[4] ? 7'd50 : note_sel[3] ? 7'd20 : note_sel[1] ? 7'd5 : 7'd10;
    legal = note_sel != '0 && (note_sel & (note_sel - 6'd1)) == '0;
    sum = {1'b0, balance} + (BAL_W+1)'(val);
    fits = !sum[BAL_W];
    refund = cancel || (!note_valid && tmo == TMO_W'(TIMEOUT-1));
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      due <= '0;
      tmo <= '0;
      balance <= '0;
      payout_amt <= '0;
      note_accept <= 1'b0;
      note_reject <= 1'b0;
      payout_valid <= 1'b0;
      paid <= 1'b0;
      done <= 1'b0;
    end else begin
      note_accept <= 1'b0;
      note_reject <= note_valid;
      done <= 1'b0;
      case (state)
        IDLE: if (start && amount_due != '0) begin
          state <= COLLECT;
          due <= amount_due;
          balance <= '0;
          paid <= 1'b0;
          tmo <= '0;
        end
        COLLECT: if (refund) begin
          state <= PAYOUT;
          payout_amt <= balance;
          payout_valid <= balance != '0;
          paid <= 1'b0;
        end else if (note_valid) begin
          tmo <= '0;
          if (legal && fits) begin
            note_accept <= 1'b1;
            note_reject <= 1'b0;
            balance <= sum[BAL_W-1:0];
            if (sum[BAL_W-1:0] >= due) begin
              state <= PAYOUT;
              payout_amt <= sum[BAL_W-1:0] - due;
              payout_valid <= sum[BAL_W-1:0] != due;
              paid <= 1'b1;
            end
          end
        end else tmo <= tmo + TMO_W'(1);
        PAYOUT: if (!payout_valid || payout_ready) begin
          payout_valid <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          balance <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cash_deposit_ctrl.sv
// tb_cash_deposit_ctrl: directed and randomized checks of cash_deposit_ctrl against a behavioural transaction model
module tb_cash_deposit_ctrl;
  localparam int BW = 7;
  localparam int TO = 16;
  localparam int MAXB = (1 << BW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cancel = 1'b0;
  logic note_valid = 1'b0;
  logic payout_ready = 1'b0;
  logic [BW-1:0] amount_due = '0;
  logic [5:0] note_sel = '0;
  logic note_accept, note_reject, payout_valid, paid, done, busy;
  logic [BW-1:0] balance, payout_amt;
  int n_chk = 0;
  int n_fail = 0;
  bit armed = 1'b0;
  int denom[6] = '{10, 5, 10, 20, 50, 100};
  int ph, m_due, m_bal, m_tmo, m_amt;
  bit m_acc, m_rej, m_pv, m_paid, m_done;
  cash_deposit_ctrl #(.BAL_W(BW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .amount_due(amount_due), .cancel(cancel),
    .note_valid(note_valid), .note_sel(note_sel), .note_accept(note_accept), .note_reject(note_reject),
    .balance(balance), .payout_valid(payout_valid), .payout_ready(payout_ready), .payout_amt(payout_amt),
    .paid(paid), .done(done), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic settle(input int amt, input bit p);
    m_amt = amt;
    m_paid = p;
    m_pv = amt != 0;
    ph = 2;
  endtask
  task automatic model_step();
    int v;
    bit legal, credit;
    v = 0;
    legal = $countones(note_sel) == 1;
    foreach (denom[i]) if (note_sel[i]) v = denom[i];
    m_acc = 0;
    m_rej = note_valid;
    m_done = 0;
    if (!rst_n) begin
      ph = 0; m_due = 0; m_bal = 0; m_tmo = 0; m_amt = 0;
      m_pv = 0; m_paid = 0; m_rej = 0;
      return;
    end
    case (ph)
      0: if (start && amount_due != 0) begin
        ph = 1; m_due = amount_due; m_bal = 0; m_paid = 0; m_tmo = 0;
      end
      1: begin
        credit = note_valid && !cancel && legal && (m_bal + v <= MAXB);
        if (credit) begin
          m_rej = 0;
          m_acc = 1;
          m_bal += v;
        end
        if (cancel) settle(m_bal, 0);
        else if (credit && m_bal >= m_due) settle(m_bal - m_due, 1);
        else if (note_valid) m_tmo = 0;
        else begin
          m_tmo++;
          if (m_tmo == TO) settle(m_bal, 0);
        end
      end
      2: if (!m_pv || payout_ready) begin
        m_pv = 0;
        m_done = 1;
        ph = 3;
      end
      default: begin
        m_bal = 0;
        ph = 0;
      end
    endcase
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    if (armed) begin
      chk("note_accept", note_accept, m_acc);
      chk("note_reject", note_reject, m_rej);
      chk("balance", balance, m_bal);
      chk("payout_valid", payout_valid, m_pv);
      if (m_pv) chk("payout_amt", payout_amt, m_amt);
      chk("paid", paid, m_paid);
      chk("done", done, m_done);
      chk("busy", busy, ph != 0);
    end
  end
  task automatic clk1();
    @(posedge clk);
    #1;
    start = 0;
    cancel = 0;
    note_valid = 0;
    note_sel = '0;
  endtask
  task automatic note(input logic [5:0] s);
    note_valid = 1;
    note_sel = s;
    clk1();
  endtask
  task automatic begin_txn(input int d);
    start = 1;
    amount_due = BW'(d);
    clk1();
  endtask
  task automatic pay();
    payout_ready = 1;
    clk1();
    payout_ready = 0;
    clk1();
  endtask
  initial begin
    rst_n = 0;
    clk1();
    clk1();
    rst_n = 1;
    armed = 1;
    chk("rst_balance", balance, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pv", payout_valid, 0);
    chk("rst_amt", payout_amt, 0);
    begin_txn(25);
    chk("t1_busy", busy, 1);
    note(6'b001000);
    chk("t1_acc", note_accept, 1);
    chk("t1_bal20", balance, 20);
    note(6'b000100);
    chk("t1_bal30", balance, 30);
    chk("t1_pv", payout_valid, 1);
    chk("t1_amt", payout_amt, 5);
    chk("t1_paid", paid, 1);
    clk1(); clk1(); clk1();
    chk("t1_hold_pv", payout_valid, 1);
    chk("t1_hold_amt", payout_amt, 5);
    payout_ready = 1;
    clk1();
    payout_ready = 0;
    chk("t1_done", done, 1);
    chk("t1_pv_drop", payout_valid, 0);
    clk1();
    chk("t1_idle", busy, 0);
    chk("t1_bal_clr", balance, 0);
    begin_txn(40);
    note(6'b000010);
    chk("t4_bal5", balance, 5);
    note(6'b000110);
    chk("t2_rej_multi", note_reject, 1);
    chk("t2_bal_kept", balance, 5);
    note(6'b000000);
    chk("t2_rej_zero", note_reject, 1);
    repeat (15) clk1();
    chk("t4_no_tmo_15", payout_valid, 0);
    chk("t4_busy_15", busy, 1);
    clk1();
    chk("t4_pv", payout_valid, 1);
    chk("t4_amt", payout_amt, 5);
    chk("t4_paid", paid, 0);
    pay();
    begin_txn(100);
    note(6'b010000);
    chk("t3_bal50", balance, 50);
    cancel = 1;
    note(6'b100000);
    chk("t3_rej", note_reject, 1);
    chk("t3_noacc", note_accept, 0);
    chk("t3_amt", payout_amt, 50);
    chk("t3_paid", paid, 0);
    pay();
    begin_txn(50);
    note(6'b010000);
    chk("t5_pv", payout_valid, 0);
    chk("t5_paid", paid, 1);
    clk1();
    chk("t5_done", done, 1);
    begin_txn(30);
    chk("t5_start_in_done", busy, 0);
    note(6'b100000);
    chk("idle_note_rej", note_reject, 1);
    chk("idle_note_bal", balance, 0);
    begin_txn(127);
    note(6'b100000);
    chk("t6_bal100", balance, 100);
    note(6'b010000);
    chk("t6_ovf_rej", note_reject, 1);
    chk("t6_ovf_bal", balance, 100);
    cancel = 1;
    clk1();
    chk("t6_pv", payout_valid, 1);
    chk("t6_amt", payout_amt, 100);
    rst_n = 0;
    clk1();
    rst_n = 1;
    chk("t6_rst_pv", payout_valid, 0);
    chk("t6_rst_amt", payout_amt, 0);
    chk("t6_rst_bal", balance, 0);
    chk("t6_rst_busy", busy, 0);
    for (int k = 0; k < 4000; k++) begin
      rst_n = $urandom_range(0, 299) != 0;
      start = $urandom_range(0, 5) == 0;
      amount_due = $urandom_range(0, 3) == 0 ? BW'($urandom) : BW'($urandom_range(0, 60));
      cancel = $urandom_range(0, (k >= 2500) ? 150 : 49) == 0;
      note_valid = $urandom_range(0, (k >= 2500) ? 40 : 2) == 0;
      note_sel = $urandom_range(0, 3) != 0 ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom);
      payout_ready = $urandom_range(0, 2) == 0;
      clk1();
    end
    rst_n = 1;
    payout_ready = 0;
    clk1();
    clk1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
